// File: rtl/seq_add32.sv
// seq_add32: byte-serial WIDTH-bit add/subtract with start/busy/done handshake
module seq_add32 #(
  parameter int WIDTH = 32
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] data_a_i,
  input  logic [WIDTH-1:0] data_b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             cout_o,
  output logic             overflow_o
);
  localparam int NB = WIDTH / 8;
  localparam int IW = $clog2(NB);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] opa_q, opb_q, result_q;
  logic [IW-1:0]    idx_q;
  logic             carry_q, busy_q, done_q, cout_q, ovf_q;
  logic [7:0]       a_byte, b_byte, sum_d;
  logic [8:0]       lo_d, hi_d;
  logic             carry_d, last;
  // byte adder in carry-select form: both carry-in outcomes computed, carry picks one
  always_comb begin
    a_byte = opa_q[{idx_q, 3'b000} +: 8];
    b_byte = opb_q[{idx_q, 3'b000} +: 8];
    lo_d = {1'b0, a_byte} + {1'b0, b_byte};
    hi_d = lo_d + 9'd1;
    {carry_d, sum_d} = carry_q ? hi_d : lo_d;
    last = idx_q == IW'(NB - 1);
  end
  // control FSM with operand latch, byte-wise result update and registered flags
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start_i) begin
          opa_q    <= data_a_i;
          opb_q    <= sub_i ? ~data_b_i : data_b_i;
          carry_q  <= sub_i;
          idx_q    <= '0;
          result_q <= '0;
          cout_q   <= 1'b0;
          ovf_q    <= 1'b0;
          busy_q   <= 1'b1;
          state_q  <= RUN;
        end
        RUN: begin
          result_q[{idx_q, 3'b000} +: 8] <= sum_d;
          carry_q <= carry_d;
          idx_q   <= idx_q + IW'(1);
          if (last) begin
            cout_q  <= carry_d;
            ovf_q   <= (opa_q[WIDTH-1] == opb_q[WIDTH-1]) && (sum_d[7] != opa_q[WIDTH-1]);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign result_o   = result_q;
  assign cout_o     = cout_q;
  assign overflow_o = ovf_q;
endmodule

// File: tb/tb_seq_add32.sv
// tb_seq_add32: directed and randomized checks of seq_add32 against an arithmetic model
module tb_seq_add32;
  localparam int W = 32;
  logic         clk = 1'b0, rst = 1'b0, start = 1'b0, sub = 1'b0;
  logic [W-1:0] data_a = '0, data_b = '0, result;
  logic         busy, done, cout, overflow;
  int           checks = 0, errors = 0;

  seq_add32 #(.WIDTH(W)) dut (
    .clock_i(clk), .reset_i(rst), .start_i(start), .sub_i(sub),
    .data_a_i(data_a), .data_b_i(data_b), .busy_o(busy), .done_o(done),
    .result_o(result), .cout_o(cout), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input logic [W-1:0] a, b, input logic s,
                                output logic [W-1:0] r, output logic c, o);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ex = s ? sa - sb : sa + sb;
    longint unsigned ua = a, ub = b;
    r = s ? a - b : a + b;
    c = s ? (ua >= ub) : ((ua + ub) >= 64'h1_0000_0000);
    o = (ex > 64'sd2147483647) || (ex < -64'sd2147483648);
  endfunction

  task automatic do_op(input logic [W-1:0] a, b, input logic s,
                       output logic [W-1:0] r, output logic c, o,
                       output int nb, output bit ok);
    data_a = a; data_b = b; sub = s; start = 1'b1;
    tick();
    start = 1'b0;
    nb = 0;
    for (int i = 0; i < 16 && done !== 1'b1; i++) begin
      if (busy === 1'b1) nb++;
      tick();
    end
    ok = done === 1'b1;
    r = result; c = cout; o = overflow;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({busy, done, result, cout, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b result=%h cout=%b ovf=%b want all 0", busy, done, result, cout, overflow);
    end
    start = 1'b1; data_a = 32'h1; data_b = 32'h2;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_beats_start got busy=%b want 0", busy);
    end
    rst = 1'b0; start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [7] = '{32'h000000FF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'd5, 32'h80000000, 32'h12345678, 32'h0};
    logic [W-1:0] tb [7] = '{32'h00000001, 32'h00000001, 32'h00000001, 32'd7, 32'h1, 32'h12345678, 32'h0};
    logic         ts [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [W-1:0] er [7] = '{32'h00000100, 32'h0, 32'h80000000, 32'hFFFFFFFE, 32'h7FFFFFFF, 32'h0, 32'h0};
    logic         ec [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic         eo [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [W-1:0] r;
    logic         c, o;
    int           nb;
    bit           ok;
    for (int i = 0; i < 7; i++) begin
      do_op(ta[i], tb[i], ts[i], r, c, o, nb, ok);
      checks++;
      if (!ok || r !== er[i] || c !== ec[i] || o !== eo[i]) begin
        errors++;
        $display("FAIL directed_%0d got done=%b result=%h cout=%b ovf=%b want done=1 result=%h cout=%b ovf=%b", i, ok, r, c, o, er[i], ec[i], eo[i]);
      end
    end
  endtask

  task automatic test_handshake();
    int nb = 0, nd = 0;
    data_a = 32'h11111111; data_b = 32'h22222222; sub = 1'b0; start = 1'b1;
    tick();
    for (int i = 0; i < 16 && done !== 1'b1; i++) begin
      if (busy === 1'b1) nb++;
      data_a = $urandom; data_b = $urandom; sub = $urandom_range(0, 1);
      tick();
    end
    checks++;
    if (nb != 4) begin
      errors++;
      $display("FAIL busy_len got %0d want 4", nb);
    end
    checks++;
    if (done !== 1'b1 || result !== 32'h33333333 || cout !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start got done=%b result=%h cout=%b ovf=%b want 1 33333333 0 0", done, result, cout, overflow);
    end
    tick();
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== 32'h33333333) begin
      errors++;
      $display("FAIL after_done got done=%b busy=%b result=%h want 0 0 33333333", done, busy, result);
    end
    for (int i = 0; i < 4; i++) begin
      if (done === 1'b1 || busy === 1'b1) nd++;
      tick();
    end
    checks++;
    if (nd != 0 || result !== 32'h33333333) begin
      errors++;
      $display("FAIL idle_hold got active_cycles=%0d result=%h want 0 33333333", nd, result);
    end
  endtask

  task automatic test_back_to_back();
    int q[$];
    int bad = 0;
    data_a = 32'd100; data_b = 32'd23; sub = 1'b0; start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1) begin
        q.push_back(i);
        if (result !== 32'd123) bad++;
      end
    end
    start = 1'b0;
    for (int i = 1; i < q.size(); i++) if (q[i] - q[i-1] != 6) bad++;
    checks++;
    if (q.size() < 6 || bad != 0) begin
      errors++;
      $display("FAIL back_to_back got pulses=%0d bad=%0d want >=6 pulses 0 bad", q.size(), bad);
    end
    while (busy === 1'b1 || done === 1'b1) tick();
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] r;
    logic         c, o;
    int           nb, nd = 0;
    bit           ok;
    data_a = 32'h7FFFFFFF; data_b = 32'h1; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, done, result, cout, overflow} !== '0) begin
      errors++;
      $display("FAIL mid_reset got busy=%b done=%b result=%h cout=%b ovf=%b want all 0", busy, done, result, cout, overflow);
    end
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1 || busy === 1'b1) nd++;
      tick();
    end
    checks++;
    if (nd != 0) begin
      errors++;
      $display("FAIL no_done_after_reset got active_cycles=%0d want 0", nd);
    end
    do_op(32'hDEADBEEF, 32'h21524111, 1'b0, r, c, o, nb, ok);
    checks++;
    if (!ok || r !== 32'h0 || c !== 1'b1 || o !== 1'b0) begin
      errors++;
      $display("FAIL op_after_reset got done=%b result=%h cout=%b ovf=%b want 1 00000000 1 0", ok, r, c, o);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, r, er;
    logic         s, c, o, ec, eo;
    int           nb;
    bit           ok;
    for (int i = 0; i < 1500; i++) begin
      a = $urandom_range(0, 3) == 0 ? 32'h80000000 >> $urandom_range(0, 1) : $urandom;
      b = $urandom_range(0, 3) == 0 ? {W{$urandom_range(0, 1) == 1}} : $urandom;
      if ($urandom_range(0, 7) == 0) b = a;
      s = $urandom_range(0, 1);
      model(a, b, s, er, ec, eo);
      do_op(a, b, s, r, c, o, nb, ok);
      checks++;
      if (!ok || nb != 4 || r !== er || c !== ec || o !== eo) begin
        errors++;
        $display("FAIL random_%0d a=%h b=%h sub=%b got done=%b busy=%0d result=%h cout=%b ovf=%b want 1 4 %h %b %b", i, a, b, s, ok, nb, r, c, o, er, ec, eo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_add32.md
# seq_add32

Multi-cycle word adder/subtractor for the SimpleALU datapath. It sits directly upstream of one instance of the existing 8-bit carry-select adder and drives it one byte per cycle. Carry-out is registered and fed back as the next byte's carry-in, so a WIDTH-bit add or subtract completes in WIDTH/8 cycles. The block produces the full result, carry-out and signed overflow, and uses a start/busy/done handshake toward the ALU control.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of 8 and at least 16.
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- sub  in  1  0 = a+b, 1 = a−b; latched with operands.
- data_a  in  WIDTH  operand A; latched on accepted start.
- data_b  in  WIDTH  operand B; latched on accepted start.
- busy  out  1  high while state is RUN.
- done  out  1  one-cycle pulse; result valid.
- result  out  WIDTH  sum/difference; held until next accepted start.
- cout  out  1  carry-out of MSB byte. For subtract, 1 means no borrow.
- overflow  out  1  two's-complement signed overflow.

## Operation
- Registers:
  - opA, opB: latched operands. On sub=1, opB holds ~data_b.
  - carry: 1 bit.
  - idx: byte index, 0..WIDTH/8−1.
  - result, cout, overflow.
  - state: IDLE/RUN/DONE.
- IDLE:
  - start=1 latches data_a, data_b (inverted if sub) and sub.
  - Sets carry=sub, idx=0, result=0, cout=0, overflow=0, and goes to RUN.
  - start=0: stay in IDLE.
- RUN, each cycle:
  - Adder inputs are opA[8·idx+7:8·idx], opB[same] and carry.
  - The sum byte is written to result[8·idx+7:8·idx]; carry ← adder carry-out; idx ← idx+1.
  - On the last byte (idx = WIDTH/8−1):
    - cout ← adder carry-out.
    - overflow ← (opA[WIDTH−1] == opB[WIDTH−1]) && (sum[WIDTH−1] != opA[WIDTH−1]), where opB is already inverted for subtract.
    - Go to DONE.
- DONE: done=1 for exactly this cycle, then unconditionally return to IDLE.
- start is ignored in RUN and DONE; no queuing.
- Operand inputs may change freely after acceptance; only the latched copies are used.
- Arithmetic is modulo 2^WIDTH. Wrap-around is reported only via cout/overflow and never saturates.
- Reset in any state:
  - state=IDLE.
  - busy=0, done=0, result=0, cout=0, overflow=0, idx=0, carry=0.
  - Any in-flight operation is discarded with no done pulse.
  - Reset has priority over a simultaneous start.

## Timing
- Start accepted at edge E0.
- busy=1 from E0 through E0+WIDTH/8; RUN spans WIDTH/8 cycles.
- result, cout and overflow are final after edge E0+WIDTH/8.
- done=1 in the cycle after edge E0+WIDTH/8.
- The earliest next start is accepted at edge E0+WIDTH/8+2. Throughput is one operation per WIDTH/8+2 cycles (6 for WIDTH=32).
- The result register updates byte-wise during RUN, so partial values are visible while busy=1. Consumers sample only when done=1 or after it.
- Adder combinational path: one 8-bit carry-select delay plus the operand byte mux; meets single-cycle timing.
- Reset values of all outputs are 0 and take effect at the first rising edge with reset=1.

## Test plan
- Byte carry chain: a=0x000000FF, b=0x00000001, sub=0 -> done after 4 RUN cycles; result=0x00000100, cout=0, overflow=0.
- Full wrap: a=0xFFFFFFFF, b=0x00000001, add -> result=0x00000000, cout=1, overflow=0. Then a=0x7FFFFFFF, b=1 -> result=0x80000000, cout=0, overflow=1.
- Subtract:
  - 5−7 -> result=0xFFFFFFFE, cout=0, overflow=0.
  - 0x80000000−1 -> result=0x7FFFFFFF, cout=1, overflow=1.
  - 0x12345678−0x12345678 -> result=0, cout=1, overflow=0.
- Handshake:
  - Pulse start during RUN and DONE with different operands; both are ignored, and the first op's result is unchanged.
  - Change data_a/data_b during RUN; the result is unaffected.
  - busy is high exactly 4 cycles and done is exactly 1 cycle.
  - Back-to-back start held high yields one op per 6 cycles.
- Reset mid-operation: assert reset in RUN at idx=2 -> next cycle all outputs are 0, state IDLE, and no done pulse appears. A new start afterwards completes correctly.
- Randomised: 10k random a/b/sub versus a reference model of WIDTH-bit add/subtract (result, carry, signed overflow). Repeat with WIDTH=16 and WIDTH=64.
